fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC and fetches from instruction SRAM.
//  Drives ID with a valid/allowin handshake on fs_ds_reg_data = {inst[31:0], pc[31:0]}.
//  Consumes ID's branch bus ds_branch_data = {br_taken, br_target[31:0]} to redirect the PC.
//  Buffers one fetched instruction while ID stalls, so no SRAM response is ever lost.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  PC_STEP     4              sequential PC increment (bytes)
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  ds_allowin      in   1   ID accepts fs_ds_reg_data this cycle
//  ds_branch_data  in   33  {br_taken, br_target}; br_taken is a one-cycle pulse from ID
//  inst_req        out  1   SRAM read request; always accepted, one outstanding maximum
//  inst_addr       out  32  SRAM word address (byte PC, [1:0]=0)
//  inst_rvalid     in   1   SRAM response valid; latency >=1 cycle after inst_req
//  inst_rdata      in   32  SRAM read data, qualified by inst_rvalid
//  fs_ds_valid     out  1   fs_ds_reg_data holds a live instruction
//  fs_ds_reg_data  out  64  {inst[31:0], pc[31:0]} to ID
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=S_REQ, pc=RESET_PC, cancel=0, fs_ds_valid=0,
//   fs_ds_reg_data=64'h0, inst_req=0, inst_addr=RESET_PC. The SRAM shares rst; no response
//   arrives after reset. Reset mid-operation drops any buffered or in-flight instruction.
//  FSM (state register + pc + cancel flag):
//   S_REQ : inst_req=1, inst_addr=pc. Next state is S_WAIT.
//   S_WAIT: inst_req=0. On inst_rvalid&!cancel: latch {inst_rdata,pc}, fs_ds_valid=1,
//           pc<=pc+PC_STEP, go to S_FULL. On inst_rvalid&cancel: clear cancel, go to S_REQ.
//   S_FULL: fs_ds_valid=1. On ds_allowin: fs_ds_valid<=0, go to S_REQ (handoff cycle).
//           Otherwise hold data stable and go nowhere.
//  Handshake: transfer = fs_ds_valid & ds_allowin. Data and valid are registered outputs,
//   stable while valid & !allowin.
//  Redirect (br_taken=1, any state), highest priority:
//   pc<=br_target, and the held instruction (S_FULL) is killed: fs_ds_valid<=0.
//   S_WAIT with no rvalid in this cycle: cancel<=1 and the state stays S_WAIT. The late
//    response is dropped, then the FSM goes to S_REQ.
//   S_WAIT with rvalid in the same cycle: the response is dropped and the FSM goes to S_REQ.
//   S_REQ: the request issued this cycle counts as outstanding, so cancel<=1 and the FSM
//    goes to S_WAIT.
//   S_FULL with ds_allowin in the same cycle: the transfer to ID still happens, because ID
//    generated the branch from an older instruction. The next fetch is br_target.
//  Throughput: one instruction per 3 cycles at 1-cycle SRAM latency (REQ->WAIT->FULL).
//   This is acceptable for this revision.
//  PC arithmetic is 32-bit, wraps 32'hFFFF_FFFC -> 0, with no trap.
//  A misaligned br_target is forced aligned (addr[1:0]=0); exceptions are out of scope.
// STRUCTURE
//  Shared package/header (riscv_defs): FS_DS_BUS_W=64, BR_BUS_W=33, RESET_PC default,
//   state encodings S_REQ/S_WAIT/S_FULL, and bus field offsets shared with ID.
//  One sub-module, fetch_pc_gen: next-PC mux (reset/branch/sequential), PC_STEP adder,
//   alignment. The remaining logic (FSM, cancel, output register) stays in fetch_stage.
// TESTING
//  1 Reset, ds_allowin=1, 1-cycle SRAM returning addr-derived data -> inst_addr sequence
//    0,4,8,...; fs_ds_reg_data=64'h002081b3_00000000 for inst 0x002081b3 at pc 0.
//  2 ds_allowin=0 for 5 cycles with valid held -> fs_ds_reg_data constant, no inst_req.
//    allowin=1 -> one transfer, then inst_addr=pc+4.
//  3 Branch pulse {1,32'h100} while S_WAIT, SRAM latency 3 -> old response dropped,
//    next inst_addr=0x100, first valid pc=0x100.
//  4 Branch pulse {1,32'h40} in the same cycle as inst_rvalid -> no valid for the old pc;
//    inst_req with addr 0x40 on the next cycle.
//  5 Branch while S_FULL & !ds_allowin -> fs_ds_valid drops next cycle; next fetch at target.
//  6 rst asserted mid-S_WAIT -> next cycle fs_ds_valid=0, inst_req=0, then inst_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_defs.sv
// Definitions shared between the IF and ID stages: bus widths, field offsets,
// fetch FSM encoding and the word-alignment helper.
package riscv_defs;

  localparam int FS_DS_BUS_W = 64;
  localparam int BR_BUS_W    = 33;

  // Field offsets of fs_ds_reg_data = {inst, pc} and ds_branch_data = {br_taken, br_target}
  localparam int FS_INST_LSB   = 32;
  localparam int FS_PC_LSB     = 0;
  localparam int BR_TAKEN_BIT  = 32;
  localparam int BR_TARGET_LSB = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fs_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch stage: reset vector, branch redirect or
// sequential step, always word aligned.
module fetch_pc_gen
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        advance,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc; otherwise a latch is inferred.
    next_pc = pc;
    if (rst) begin
      next_pc = align_word(RESET_PC);
    end else if (br_taken) begin
      next_pc = align_word(br_target);
    end else if (advance) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-outstanding SRAM reads and holds one
// fetched instruction for ID behind a valid/allowin handshake.
module fetch_stage
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds_allowin,
  input  logic [BR_BUS_W-1:0]    ds_branch_data,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_rvalid,
  input  logic [31:0]            inst_rdata,
  output logic                   fs_ds_valid,
  output logic [FS_DS_BUS_W-1:0] fs_ds_reg_data
);

  fs_state_e   state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        cancel;
  logic        br_taken;
  logic [31:0] br_target;
  logic        accept;

  assign br_taken  = ds_branch_data[BR_TAKEN_BIT];
  assign br_target = ds_branch_data[BR_TARGET_LSB +: 32];
  assign accept    = (state == S_WAIT) && inst_rvalid && !cancel;
  assign inst_addr = pc;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .rst       (rst),
    .br_taken  (br_taken),
    .br_target (br_target),
    .advance   (accept),
    .pc        (pc),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    pc <= next_pc;
    if (rst) begin
      state          <= S_REQ;
      cancel         <= 1'b0;
      inst_req       <= 1'b0;
      fs_ds_valid    <= 1'b0;
      fs_ds_reg_data <= '0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (inst_req) begin
            // A redirect here cannot recall the request already on the bus.
            state    <= S_WAIT;
            inst_req <= 1'b0;
            cancel   <= br_taken;
          end else begin
            inst_req <= 1'b1;  // first cycle out of reset: raise the request
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            cancel <= 1'b0;
            if (cancel || br_taken) begin
              state    <= S_REQ;
              inst_req <= 1'b1;
            end else begin
              state                             <= S_FULL;
              fs_ds_valid                       <= 1'b1;
              fs_ds_reg_data[FS_INST_LSB +: 32] <= inst_rdata;
              fs_ds_reg_data[FS_PC_LSB +: 32]   <= pc;
            end
          end else if (br_taken) begin
            cancel <= 1'b1;
          end
        end
        S_FULL: begin
          // With allowin the transfer completes even when a branch kills the stream.
          if (ds_allowin || br_taken) begin
            state       <= S_REQ;
            fs_ds_valid <= 1'b0;
            inst_req    <= 1'b1;
          end
        end
        default: begin
          state    <= S_REQ;
          inst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then random allowin/branch/reset/latency against a stream model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [32:0] ds_branch_data = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        fs_ds_valid;
  logic [63:0] fs_ds_reg_data;

  int total = 0;
  int bad   = 0;

  // SRAM model state
  logic        pend = 1'b0;
  int          due = 0;
  logic [31:0] paddr = '0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // Stream model state
  logic        m_pv = 1'b0;
  logic        m_pallow = 1'b0;
  logic        m_pbr = 1'b0;
  logic        m_prst = 1'b0;
  logic [63:0] m_pd = '0;
  logic [31:0] m_exp_pc = RESET_PC;
  int          m_idle = 0;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ds_allowin     (ds_allowin),
    .ds_branch_data (ds_branch_data),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_rvalid    (inst_rvalid),
    .inst_rdata     (inst_rdata),
    .fs_ds_valid    (fs_ds_valid),
    .fs_ds_reg_data (fs_ds_reg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0020_81b3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies inputs for one cycle, plays the SRAM, returns 1 time unit after the next posedge.
  task automatic cycle(input logic r, input logic a, input logic b, input logic [31:0] t);
    logic        req_now;
    logic [31:0] addr_now;
    rst            = r;
    ds_allowin     = a;
    ds_branch_data = {b, t};
    inst_rvalid    = pend && (due == 0);
    inst_rdata     = inst_rvalid ? mem(paddr) : $urandom();
    @(negedge clk);
    req_now  = inst_req;
    addr_now = inst_addr;
    @(posedge clk);
    #1;
    if (r) begin
      pend = 1'b0;
    end else begin
      if (inst_rvalid) pend = 1'b0;
      else if (pend) due--;
      if (req_now) begin
        check("one_outstanding", pend, 1'b0);
        pend  = 1'b1;
        paddr = addr_now;
        due   = int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!fs_ds_valid && n < max) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("wait_valid_timeout", fs_ds_valid, 1'b1);
  endtask

  task automatic wait_req(input int max);
    int n;
    n = 0;
    while (!inst_req && n < max) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("wait_req_timeout", inst_req, 1'b1);
  endtask

  // Stream model: instructions must appear in program order with correct data,
  // hold while stalled, vanish after transfer/kill, and requests go to the next expected pc.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (m_prst) begin
        check("rst_valid", fs_ds_valid, 1'b0);
        check("rst_req", inst_req, 1'b0);
        check("rst_data", fs_ds_reg_data, 64'h0);
        check("rst_addr", inst_addr, RESET_PC);
      end
      if (rst) begin
        m_exp_pc = RESET_PC;
        m_pv     = 1'b0;
        m_pallow = 1'b0;
        m_pbr    = 1'b0;
        m_prst   = 1'b1;
        m_idle   = 0;
      end else begin
        if (fs_ds_valid && !m_pv) begin
          check("new_inst", fs_ds_reg_data, {mem(m_exp_pc), m_exp_pc});
          m_exp_pc = m_exp_pc + 32'd4;
        end
        if (m_pv && !m_pallow && !m_pbr) begin
          check("hold_valid", fs_ds_valid, 1'b1);
          check("hold_data", fs_ds_reg_data, m_pd);
        end
        if (m_pv && (m_pallow || m_pbr)) check("drop_after_xfer", fs_ds_valid, 1'b0);
        if (inst_req) check("req_addr", inst_addr, m_exp_pc);
        if (ds_branch_data[32]) m_exp_pc = {ds_branch_data[31:2], 2'b00};
        m_idle = (inst_req || fs_ds_valid) ? 0 : m_idle + 1;
        if (m_idle == 26) check("liveness_idle", m_idle, 25);
        m_pv     = fs_ds_valid;
        m_pallow = ds_allowin;
        m_pbr    = ds_branch_data[32];
        m_pd     = fs_ds_reg_data;
        m_prst   = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : main
    int          n;
    logic [63:0] hold;

    lat_lo = 1;
    lat_hi = 1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("reset_valid", fs_ds_valid, 1'b0);
    check("reset_data", fs_ds_reg_data, 64'h0);
    check("reset_req", inst_req, 1'b0);
    check("reset_addr", inst_addr, 32'h0);

    // Sequential fetch, 1-cycle SRAM, ID always ready
    wait_valid(10, n);
    check("t1_first_inst", fs_ds_reg_data, 64'h002081b3_00000000);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("t1_handoff_valid", fs_ds_valid, 1'b0);
    check("t1_req", inst_req, 1'b1);
    check("t1_addr", inst_addr, 32'h4);
    for (int k = 2; k < 5; k++) begin
      wait_valid(10, n);
      check("t1_req_to_valid", n, 2);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t1_addr_seq", inst_addr, 32'(k * 4));
    end

    // ID stall holds the instruction, no new request
    wait_valid(10, n);
    hold = fs_ds_reg_data;
    check("t2_held_inst", hold, 64'h002081a3_00000010);
    repeat (5) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("t2_hold_valid", fs_ds_valid, 1'b1);
      check("t2_hold_data", fs_ds_reg_data, hold);
      check("t2_no_req", inst_req, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("t2_after_valid", fs_ds_valid, 1'b0);
    check("t2_next_addr", inst_addr, 32'h14);

    // Branch while waiting on a 3-cycle SRAM: late response dropped
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("t3_in_wait", inst_req, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    wait_req(10);
    check("t3_target_addr", inst_addr, 32'h100);
    wait_valid(20, n);
    check("t3_first_inst", fs_ds_reg_data, 64'h002080b3_00000100);

    // Branch in the same cycle as the response
    lat_lo = 1;
    lat_hi = 1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_seq_addr", inst_addr, 32'h104);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    check("t4_no_valid", fs_ds_valid, 1'b0);
    check("t4_req", inst_req, 1'b1);
    check("t4_addr", inst_addr, 32'h40);
    wait_valid(10, n);
    check("t4_inst", fs_ds_reg_data, 64'h002081f3_00000040);

    // Kill of a stalled instruction, misaligned target
    cycle(1'b0, 1'b0, 1'b1, 32'h203);
    check("t5_killed", fs_ds_valid, 1'b0);
    check("t5_req", inst_req, 1'b1);
    check("t5_aligned_addr", inst_addr, 32'h200);
    wait_valid(10, n);
    check("t5_inst", fs_ds_reg_data, 64'h002083b3_00000200);

    // Transfer plus branch to the top word, then wrap to 0
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_addr_top", inst_addr, 32'hFFFF_FFFC);
    wait_valid(10, n);
    check("wrap_inst", fs_ds_reg_data, 64'hffdf7e4f_fffffffc);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr_zero", inst_addr, 32'h0);

    // Reset during S_WAIT
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_valid", fs_ds_valid, 1'b0);
    check("t6_req", inst_req, 1'b0);
    check("t6_data", fs_ds_reg_data, 64'h0);
    wait_req(10);
    check("t6_addr", inst_addr, RESET_PC);
    wait_valid(20, n);
    check("t6_inst", fs_ds_reg_data, 64'h002081b3_00000000);

    // Random traffic against the stream model
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        a;
      logic        b;
      logic [31:0] t;
      r = ($urandom_range(199, 0) == 0);
      a = ($urandom_range(9, 0) < 7);
      b = ($urandom_range(19, 0) == 0);
      t = $urandom();
      if ($urandom_range(1, 0) == 1) t = {20'h0, t[11:0]};
      cycle(r, a, b, t);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
